// File: rtl/inj_scan_ctrl.sv
// inj_scan_ctrl: sequences a multi-step injection scan. For every step it
// strobes the pixel-config SPI, waits for the load to complete, issues a
// burst of injection strobes at a fixed period (pausing under FIFO
// backpressure) and then waits for the readout path to stay idle before
// moving on to the next step.
//
// Optional build macro INJ_SCAN_TIMEOUT_EN adds a watchdog on every
// externally paced wait; on expiry the scan ends with ERROR set.
module inj_scan_ctrl #(
    parameter int STEP_WIDTH     = 8,
    parameter int CNT_WIDTH      = 16,
    parameter int DRAIN_IDLE     = 64,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                  BUS_CLK,
    input  logic                  BUS_RST,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic [STEP_WIDTH-1:0] N_STEPS,
    input  logic [CNT_WIDTH-1:0]  N_INJ,
    input  logic [CNT_WIDTH-1:0]  INJ_PERIOD,
    output logic                  CONF_START,
    input  logic                  CONF_BUSY,
    output logic                  INJ_START,
    input  logic                  FIFO_NEAR_FULL,
    input  logic                  RO_IDLE,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERROR,
    output logic [STEP_WIDTH-1:0] STEP,
    output logic [CNT_WIDTH-1:0]  INJ_CNT
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CONF,
        S_CONF_ACK,
        S_CONF_WAIT,
        S_INJ,
        S_INJ_WAIT,
        S_DRAIN,
        S_NEXT,
        S_FINISH
    } state_t;

    localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [STEP_WIDTH-1:0] STEP_ONE   = STEP_WIDTH'(1);
    // Last idle-count value before the drain is considered complete.
    localparam logic [CNT_WIDTH-1:0]  DRAIN_LAST = CNT_WIDTH'(DRAIN_IDLE - 1);

    state_t                state_q, state_d;
    logic [STEP_WIDTH-1:0] n_steps_q, n_steps_d;
    logic [CNT_WIDTH-1:0]  n_inj_q, n_inj_d;
    logic [CNT_WIDTH-1:0]  period_q, period_d;
    logic [STEP_WIDTH-1:0] step_q, step_d;
    logic [CNT_WIDTH-1:0]  inj_cnt_q, inj_cnt_d;
    logic [CNT_WIDTH-1:0]  per_cnt_q, per_cnt_d;
    logic [CNT_WIDTH-1:0]  idle_cnt_q, idle_cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  conf_start_q, conf_start_d;
    logic                  inj_start_q, inj_start_d;

`ifdef INJ_SCAN_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              error_q, error_d;
    logic              watched;
`else
    // Keeps the watchdog limit referenced in builds without the watchdog.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    // Next-state and registered-output logic for the scan sequencer.
    always_comb begin
        state_d      = state_q;
        n_steps_d    = n_steps_q;
        n_inj_d      = n_inj_q;
        period_d     = period_q;
        step_d       = step_q;
        inj_cnt_d    = inj_cnt_q;
        per_cnt_d    = per_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        busy_d       = busy_q;
        done_d       = done_q;
        conf_start_d = 1'b0;
        inj_start_d  = 1'b0;
`ifdef INJ_SCAN_TIMEOUT_EN
        error_d      = error_q;
        wait_cnt_d   = '0;
        watched      = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (START && !ABORT) begin
                    n_steps_d = N_STEPS;
                    n_inj_d   = N_INJ;
                    period_d  = (INJ_PERIOD == '0) ? CNT_ONE : INJ_PERIOD;
                    step_d    = '0;
                    inj_cnt_d = '0;
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
`ifdef INJ_SCAN_TIMEOUT_EN
                    error_d   = 1'b0;
`endif
                    state_d   = (N_STEPS == '0) ? S_FINISH : S_CONF;
                end
            end
            S_CONF: begin
                state_d = S_CONF_ACK;
            end
            S_CONF_ACK: begin
                if (CONF_BUSY) begin
                    state_d = S_CONF_WAIT;
                end
            end
            S_CONF_WAIT: begin
                if (!CONF_BUSY) begin
                    inj_cnt_d = '0;
                    state_d   = (n_inj_q != '0) ? S_INJ : S_DRAIN;
                end
            end
            S_INJ: begin
                if (!FIFO_NEAR_FULL) begin
                    inj_start_d = 1'b1;
                    if (inj_cnt_q != n_inj_q) begin
                        inj_cnt_d = inj_cnt_q + CNT_ONE;
                    end
                    // The strobe cycle itself is the first cycle of the period.
                    per_cnt_d = CNT_ONE;
                    if (period_q != CNT_ONE) begin
                        state_d = S_INJ_WAIT;
                    end else if (inj_cnt_d < n_inj_q) begin
                        state_d = S_INJ;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_INJ_WAIT: begin
                if (per_cnt_q >= period_q - CNT_ONE) begin
                    state_d = (inj_cnt_q < n_inj_q) ? S_INJ : S_DRAIN;
                end else begin
                    per_cnt_d = per_cnt_q + CNT_ONE;
                end
            end
            S_DRAIN: begin
                if (!RO_IDLE) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q >= DRAIN_LAST) begin
                    state_d = S_NEXT;
                end else begin
                    idle_cnt_d = idle_cnt_q + CNT_ONE;
                end
            end
            S_NEXT: begin
                if (step_q >= n_steps_q - STEP_ONE) begin
                    state_d = S_FINISH;
                end else begin
                    step_d  = step_q + STEP_ONE;
                    state_d = S_CONF;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every drain starts counting from zero.
        if (state_d == S_DRAIN && state_q != S_DRAIN) begin
            idle_cnt_d = '0;
        end

`ifdef INJ_SCAN_TIMEOUT_EN
        // The watchdog only runs while stuck in an externally paced wait.
        watched = (state_q == S_CONF_ACK) || (state_q == S_CONF_WAIT) ||
                  (state_q == S_DRAIN) ||
                  (state_q == S_INJ && FIFO_NEAR_FULL);
        if (watched && state_d == state_q) begin
            if (wait_cnt_q >= WAIT_LAST) begin
                error_d = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = S_IDLE;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
`endif

        // Abort wins over everything else once a scan is running.
        if (ABORT && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            step_d      = step_q;
            inj_cnt_d   = inj_cnt_q;
            inj_start_d = 1'b0;
`ifdef INJ_SCAN_TIMEOUT_EN
            error_d     = error_q;
            wait_cnt_d  = '0;
`endif
        end

        // CONF_START is high for exactly the one cycle spent in CONF.
        conf_start_d = (state_d == S_CONF);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_q      <= S_IDLE;
            n_steps_q    <= '0;
            n_inj_q      <= '0;
            period_q     <= CNT_ONE;
            step_q       <= '0;
            inj_cnt_q    <= '0;
            per_cnt_q    <= '0;
            idle_cnt_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            conf_start_q <= 1'b0;
            inj_start_q  <= 1'b0;
`ifdef INJ_SCAN_TIMEOUT_EN
            wait_cnt_q   <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            n_steps_q    <= n_steps_d;
            n_inj_q      <= n_inj_d;
            period_q     <= period_d;
            step_q       <= step_d;
            inj_cnt_q    <= inj_cnt_d;
            per_cnt_q    <= per_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            conf_start_q <= conf_start_d;
            inj_start_q  <= inj_start_d;
`ifdef INJ_SCAN_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
            error_q      <= error_d;
`endif
        end
    end

    assign CONF_START = conf_start_q;
    assign INJ_START  = inj_start_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign STEP       = step_q;
    assign INJ_CNT    = inj_cnt_q;
`ifdef INJ_SCAN_TIMEOUT_EN
    assign ERROR      = error_q;
`else
    assign ERROR      = 1'b0;
`endif

endmodule
